// File: rtl/alu_pkg.sv
// Shared opcode encodings and state type for the sequential EX-stage ALU.
package alu_pkg;

  localparam int unsigned ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] OP_AND   = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] OP_OR    = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] OP_ADD   = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] OP_XOR   = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] OP_SUB   = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] OP_NOR   = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] OP_RSVD  = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] OP_SLT   = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] OP_SLL   = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] OP_SRL   = 4'b1001;
  localparam logic [ALU_CTRL_W-1:0] OP_SRA   = 4'b1010;
  localparam logic [ALU_CTRL_W-1:0] OP_SLTU  = 4'b1011;
  localparam logic [ALU_CTRL_W-1:0] OP_MULTU = 4'b1100;
  localparam logic [ALU_CTRL_W-1:0] OP_DIVU  = 4'b1101;
  localparam logic [ALU_CTRL_W-1:0] OP_MFHI  = 4'b1110;
  localparam logic [ALU_CTRL_W-1:0] OP_MFLO  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// ALU_EARLY_TERM_EN: multiply stops once the unconsumed multiplier bits are all zero.
module alu_muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned PW    = 2 * WIDTH;

  logic             run_q, run_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH:0]   trial;
  logic             last;
  logic             fit;

  // Multiply: acc accumulates, b is the left-shifting multiplicand, m the multiplier.
  // Divide: acc = {remainder, quotient}, b[WIDTH-1:0] the divisor.
  always_comb begin
    run_d = run_q;
    div_d = div_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    b_d   = b_q;
    m_d   = m_q;
    done  = 1'b0;
    last  = (cnt_q == CNT_W'(WIDTH - 1));
    trial = acc_q[PW-1:WIDTH-1];
    fit   = (trial >= {1'b0, b_q[WIDTH-1:0]});
    if (start) begin
      run_d = 1'b1;
      div_d = is_div;
      cnt_d = '0;
      m_d   = op_b;
      acc_d = is_div ? {{WIDTH{1'b0}}, op_a} : '0;
      b_d   = {{WIDTH{1'b0}}, (is_div ? op_b : op_a)};
    end else if (run_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (div_q) begin
        acc_d = {(fit ? WIDTH'(trial - {1'b0, b_q[WIDTH-1:0]}) : trial[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], fit};
        done  = last;
      end else begin
        if (m_q[0]) begin
          acc_d = acc_q + b_q;
        end
        b_d = b_q << 1;
        m_d = m_q >> 1;
`ifdef ALU_EARLY_TERM_EN
        done = last || (m_q[WIDTH-1:1] == '0);
`else
        done = last;
`endif
      end
      if (done) begin
        run_d = 1'b0;
      end
    end
  end

  assign hi = acc_d[PW-1:WIDTH];
  assign lo = acc_d[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      b_q   <= '0;
      m_q   <= '0;
    end else begin
      run_q <= run_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      b_q   <= b_d;
      m_q   <= m_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered EX-stage ALU with valid/ready handshake, HI/LO and iterative MULTU/DIVU.
// Optional ALU_EARLY_TERM_EN shortens MULTU when the multiplier runs out of set bits.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CTRL_W-1:0] ctrl,
  input  logic [WIDTH-1:0]      input_1,
  input  logic [WIDTH-1:0]      input_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      result,
  output logic                  zero,
  output logic                  overflow,
  output logic                  busy
);

  alu_state_e       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             accept;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] sum, diff;
  logic [SHAMT_W-1:0] shamt;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign md_start = accept && ((ctrl == OP_MULTU) || (ctrl == OP_DIVU));

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .is_div (ctrl == OP_DIVU),
    .op_a   (input_1),
    .op_b   (input_2),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  // Single-cycle datapath
  always_comb begin
    sum     = input_1 + input_2;
    diff    = input_1 - input_2;
    shamt   = input_2[SHAMT_W-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ctrl)
      OP_AND:  alu_res = input_1 & input_2;
      OP_OR:   alu_res = input_1 | input_2;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (input_1[WIDTH-1] == input_2[WIDTH-1]) && (sum[WIDTH-1] != input_1[WIDTH-1]);
      end
      OP_XOR:  alu_res = input_1 ^ input_2;
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (input_1[WIDTH-1] != input_2[WIDTH-1]) && (diff[WIDTH-1] != input_1[WIDTH-1]);
      end
      OP_NOR:  alu_res = ~(input_1 | input_2);
      OP_SLT:  alu_res = WIDTH'($signed(input_1) < $signed(input_2));
      OP_SLTU: alu_res = WIDTH'(input_1 < input_2);
      OP_SLL:  alu_res = input_1 << shamt;
      OP_SRL:  alu_res = input_1 >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(input_1) >>> shamt);
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Handshake, state and result/HI/LO register updates
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    busy_d      = busy_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (md_start) begin
            if (ctrl == OP_DIVU) begin
              state_d = DIV;
            end else begin
              state_d = MUL;
            end
            busy_d = 1'b1;
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            overflow_d  = alu_ovf;
            out_valid_d = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        if (md_done) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          hi_d        = md_hi;
          lo_d        = md_lo;
          result_d    = md_lo;
          zero_d      = (md_lo == '0);
          overflow_d  = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=32) with an in-order expected-result queue.
module tb_alu_seq;

  localparam int unsigned W = 32;

  localparam logic [3:0] C_AND = 4'h0, C_OR = 4'h1, C_ADD = 4'h2, C_XOR = 4'h3;
  localparam logic [3:0] C_SUB = 4'h4, C_NOR = 4'h5, C_RSV = 4'h6, C_SLT = 4'h7;
  localparam logic [3:0] C_SLL = 4'h8, C_SRL = 4'h9, C_SRA = 4'hA, C_SLTU = 4'hB;
  localparam logic [3:0] C_MUL = 4'hC, C_DIV = 4'hD, C_MFHI = 4'hE, C_MFLO = 4'hF;

  logic         clk, reset, in_valid, in_ready, out_valid, out_ready;
  logic         zero, overflow, busy;
  logic [3:0]   ctrl;
  logic [W-1:0] input_1, input_2, result;

  int           cyc = 0;
  int           n_vec, n_err;
  logic [W-1:0] m_hi, m_lo;
  logic [W-1:0] obs_res;
  logic         obs_zero, obs_ovf;
  int           nb;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
    int           due;
    bit           seen;
  } exp_t;
  exp_t expq[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl      (ctrl),
    .input_1   (input_1),
    .input_2   (input_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int mul_lat(input logic [W-1:0] b);
`ifdef ALU_EARLY_TERM_EN
    int k = 1;
    for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
    return k + 1;
`else
    return W + 1;
`endif
  endfunction

  // Architectural model: what the op must return, plus cycles until out_valid.
  function automatic void model_push(input logic [3:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input int c);
    longint       sa, sb, s;
    logic [63:0]  p;
    logic [W-1:0] r;
    logic         v;
    int           lat;
    r = '0; v = 1'b0; lat = 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      C_AND:  r = a & b;
      C_OR:   r = a | b;
      C_ADD:  begin s = sa + sb; r = a + b; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      C_XOR:  r = a ^ b;
      C_SUB:  begin s = sa - sb; r = a - b; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      C_NOR:  r = ~(a | b);
      C_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      C_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      C_SLL:  r = a << b[4:0];
      C_SRL:  r = a >> b[4:0];
      C_SRA:  r = $signed(a) >>> b[4:0];
      C_MUL:  begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; lat = mul_lat(b);
      end
      C_DIV:  begin
        if (b == '0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
        r = m_lo; lat = W + 1;
      end
      C_MFHI: r = m_hi;
      C_MFLO: r = m_lo;
      default: r = '0;
    endcase
    expq.push_back('{res: r, zero: (r == '0), ovf: v, due: c + lat, seen: 1'b0});
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int g = 0;
    ctrl = op; input_1 = a; input_2 = b; in_valid = 1'b1;
    #1;
    while (!in_ready && g < 200) begin @(negedge clk); #1; g++; end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL issue_timeout: in_ready=%b, expected 1", in_ready);
    end else begin
      model_push(op, a, b, cyc);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(output int nbusy);
    int g = 0;
    nbusy = 0;
    while (expq.size() != 0 && g < 400) begin
      if (busy) nbusy++;
      @(negedge clk); #3; g++;
    end
    if (expq.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", expq.size());
      expq.delete();
    end
  endtask

  // Compare DUT outputs against the queue head on every cycle a result is presented.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_valid: out_valid=1 result=%h, expected no result", result);
        end else begin
          if (!expq[0].seen) begin
            chk("latency_cycle", 32'(cyc), 32'(expq[0].due));
            expq[0].seen = 1'b1;
            obs_res = result; obs_zero = zero; obs_ovf = overflow;
          end
          chk("result", result, expq[0].res);
          chk("zero", 32'(zero), 32'(expq[0].zero));
          chk("overflow", 32'(overflow), 32'(expq[0].ovf));
          if (out_ready) void'(expq.pop_front());
        end
      end else if (expq.size() != 0 && !expq[0].seen && cyc >= expq[0].due) begin
        n_vec++; n_err++;
        $display("FAIL late_result: out_valid=0 at cycle %0d, expected 1 by %0d", cyc, expq[0].due);
      end
    end
  end

  initial begin
    n_vec = 0; n_err = 0; m_hi = '0; m_lo = '0;
    obs_res = '0; obs_zero = 1'b0; obs_ovf = 1'b0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ctrl = '0; input_1 = '0; input_2 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("idle_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // ADD overflow under back-pressure, second op waits for out_ready
    out_ready = 1'b0;
    issue(C_ADD, 32'h7FFFFFFF, 32'h00000001);
    ctrl = C_SUB; input_1 = 32'd5; input_2 = 32'd5; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_result_hold", result, 32'h80000000);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    chk("add_res", obs_res, 32'h80000000);
    chk("add_ovf", 32'(obs_ovf), 32'd1);
    chk("add_zero", 32'(obs_zero), 32'd0);
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    model_push(C_SUB, 32'd5, 32'd5, cyc);
    @(negedge clk);
    in_valid = 1'b0;
    drain(nb);
    chk("sub_res", obs_res, 32'd0);
    chk("sub_zero", 32'(obs_zero), 32'd1);
    chk("sub_ovf", 32'(obs_ovf), 32'd0);

    issue(C_SLT, 32'hFFFFFFFF, 32'h00000001); drain(nb);
    chk("slt_res", obs_res, 32'd1);
    issue(C_SLTU, 32'hFFFFFFFF, 32'h00000001); drain(nb);
    chk("sltu_res", obs_res, 32'd0);
    issue(C_SRA, 32'h80000000, 32'h00000024); drain(nb);
    chk("sra_res", obs_res, 32'hF8000000);

    // back-to-back single-cycle ops, one per cycle
    issue(C_AND, 32'hF0F0A5A5, 32'h0FF05A5A);
    issue(C_OR,  32'hF0F0A5A5, 32'h0FF05A5A);
    issue(C_XOR, 32'hF0F0A5A5, 32'h0FF05A5A);
    issue(C_NOR, 32'h00000000, 32'h00000000);
    issue(C_SLL, 32'h00000001, 32'hFFFFFFFF);
    issue(C_SRL, 32'h80000000, 32'h00000021);
    issue(C_RSV, 32'h12345678, 32'h9ABCDEF0);
    issue(C_ADD, 32'h80000000, 32'h80000000);
    issue(C_SUB, 32'h80000000, 32'h00000001);
    issue(C_SUB, 32'h00000000, 32'h80000000);
    issue(C_SLT, 32'h00000003, 32'hFFFFFFFE);
    drain(nb);

    issue(C_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF); drain(nb);
    chk("mul_busy_cycles", 32'(nb), 32'd32);
    chk("mul_lo", obs_res, 32'h00000001);
    issue(C_MFHI, 32'h0, 32'h0); drain(nb);
    chk("mfhi_mul", obs_res, 32'hFFFFFFFE);
    issue(C_MFLO, 32'h0, 32'h0); drain(nb);
    chk("mflo_mul", obs_res, 32'h00000001);

    issue(C_MUL, 32'd3, 32'd1); drain(nb);
`ifdef ALU_EARLY_TERM_EN
    chk("mul3x1_busy_cycles", 32'(nb), 32'd1);
`else
    chk("mul3x1_busy_cycles", 32'(nb), 32'd32);
`endif
    chk("mul3x1_lo", obs_res, 32'd3);

    issue(C_DIV, 32'd100, 32'd7); drain(nb);
    chk("div_lo", obs_res, 32'd14);
    issue(C_MFHI, 32'h0, 32'h0); drain(nb);
    chk("div_hi", obs_res, 32'd2);
    issue(C_DIV, 32'd9, 32'd0); drain(nb);
    chk("div0_lo", obs_res, 32'hFFFFFFFF);
    issue(C_MFHI, 32'h0, 32'h0); drain(nb);
    chk("div0_hi", obs_res, 32'd9);

    // ops offered while busy must wait, then see the new HI/LO
    issue(C_MUL, 32'h12345678, 32'h9ABCDEF0);
    issue(C_MFLO, 32'h0, 32'h0);
    issue(C_MFHI, 32'h0, 32'h0);
    issue(C_DIV, 32'hDEADBEEF, 32'h00001234);
    issue(C_MFHI, 32'h0, 32'h0);
    drain(nb);

    // asynchronous reset in the middle of a multiply
    issue(C_MUL, 32'h12345678, 32'h80000001);
    repeat (9) @(negedge clk);
    #3;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_result", result, 32'd0);
    expq.delete();
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    issue(C_MFHI, 32'h0, 32'h0); drain(nb);
    chk("rst_hi", obs_res, 32'd0);
    issue(C_MFLO, 32'h0, 32'h0); drain(nb);
    chk("rst_lo", obs_res, 32'd0);
    issue(C_ADD, 32'd2, 32'd3); drain(nb);
    chk("post_rst_add", obs_res, 32'd5);
    issue(C_MUL, 32'd6, 32'd7); drain(nb);
    chk("post_rst_mul", obs_res, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
